// File: rtl/invader_game_ctrl.sv
// Game-state engine for the invader game. Advances once per frame_tick and
// hands the invader row, ship and bullet state to the pixel formatter.
// The game FSM state is visible on the status output.
module invader_game_ctrl #(
    parameter logic [19:0] INIT_ARRAY    = 20'b00111111111111111100,
    parameter int          INV_PERIOD    = 30,
    parameter int          BULLET_PERIOD = 4,
    parameter int          SHIP_PERIOD   = 6,
    parameter int          SHIP_START    = 9
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    output logic [19:0] invArray,
    output logic [4:0]  invLine,
    output logic [4:0]  shipX,
    output logic [4:0]  bulletX,
    output logic [3:0]  bulletY,
    output logic        bulletFlying,
    output logic [1:0]  status
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WON  = 2'b10,
        ST_LOST = 2'b11
    } state_t;

    localparam logic [5:0] INV_LAST    = 6'(INV_PERIOD - 1);
    localparam logic [5:0] BULLET_LAST = 6'(BULLET_PERIOD - 1);
    localparam logic [5:0] SHIP_LAST   = 6'(SHIP_PERIOD - 1);
    localparam logic [4:0] SHIP_INIT   = 5'(SHIP_START);
    localparam logic [4:0] LOST_LINE   = 5'd13;
    localparam logic [4:0] RIGHT_EDGE  = 5'd19;
    localparam logic [3:0] LAUNCH_ROW  = 4'd12;

    state_t      state_q, state_d;
    logic [19:0] inv_q, inv_d;
    logic [4:0]  line_q, line_d;
    logic [4:0]  ship_q, ship_d;
    logic [4:0]  bx_q, bx_d;
    logic [3:0]  by_q, by_d;
    logic        fly_q, fly_d;
    logic [5:0]  bdiv_q, bdiv_d;
    logic [5:0]  sdiv_q, sdiv_d;
    logic [5:0]  idiv_q, idiv_d;
    logic        pend_q, pend_d;
    logic        fire_q;

    logic [19:0] bit_mask;
    logic        hit;
    logic        fire_rise;
    logic        one_button;

    assign bit_mask   = 20'd1 << bx_q;
    // Hit uses the bullet position and invader row as they stood at tick start.
    assign hit        = fly_q && (by_q == line_q[3:0]) && ((inv_q & bit_mask) != 20'd0);
    assign fire_rise  = btn_fire && !fire_q;
    assign one_button = btn_left ^ btn_right;

    // Next-state and next-game-values; every target defaults to hold.
    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        line_d  = line_q;
        ship_d  = ship_q;
        bx_d    = bx_q;
        by_d    = by_q;
        fly_d   = fly_q;
        bdiv_d  = bdiv_q;
        sdiv_d  = sdiv_q;
        idiv_d  = idiv_q;
        pend_d  = pend_q;

        // A tick always consumes (or discards) a pending fire request.
        if (frame_tick) begin
            pend_d = 1'b0;
        end else if (fire_rise) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && pend_q) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // Outcome of the previous update is resolved before any new tick.
                if (inv_q == 20'd0) begin
                    state_d = ST_WON;
                end else if (line_q == LOST_LINE) begin
                    state_d = ST_LOST;
                end else if (frame_tick) begin
                    // Hit check, otherwise bullet climb.
                    if (hit) begin
                        inv_d  = inv_q & ~bit_mask;
                        fly_d  = 1'b0;
                        bdiv_d = 6'd0;
                    end else if (fly_q) begin
                        if (bdiv_q == BULLET_LAST) begin
                            bdiv_d = 6'd0;
                            if (by_q == 4'd0) begin
                                fly_d = 1'b0;
                            end else begin
                                by_d = by_q - 4'd1;
                            end
                        end else begin
                            bdiv_d = bdiv_q + 6'd1;
                        end
                    end else begin
                        bdiv_d = 6'd0;
                    end

                    // Launch only from an idle bullet; fire while flying is dropped.
                    if (pend_q && !fly_q) begin
                        bx_d   = ship_q;
                        by_d   = LAUNCH_ROW;
                        fly_d  = 1'b1;
                        bdiv_d = 6'd0;
                    end

                    // Ship moves only while exactly one direction is held.
                    if (one_button) begin
                        if (sdiv_q == SHIP_LAST) begin
                            sdiv_d = 6'd0;
                            if (btn_left) begin
                                if (ship_q != 5'd0) begin
                                    ship_d = ship_q - 5'd1;
                                end
                            end else if (ship_q != RIGHT_EDGE) begin
                                ship_d = ship_q + 5'd1;
                            end
                        end else begin
                            sdiv_d = sdiv_q + 6'd1;
                        end
                    end else begin
                        sdiv_d = 6'd0;
                    end

                    // Invader descent.
                    if (idiv_q == INV_LAST) begin
                        idiv_d = 6'd0;
                        line_d = line_q + 5'd1;
                    end else begin
                        idiv_d = idiv_q + 6'd1;
                    end
                end
            end

            ST_WON, ST_LOST: begin
                // Restart straight into play with a fresh field.
                if (frame_tick && pend_q) begin
                    state_d = ST_PLAY;
                    inv_d   = INIT_ARRAY;
                    line_d  = 5'd0;
                    ship_d  = SHIP_INIT;
                    bx_d    = 5'd0;
                    by_d    = 4'd0;
                    fly_d   = 1'b0;
                    bdiv_d  = 6'd0;
                    sdiv_d  = 6'd0;
                    idiv_d  = 6'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and game registers; reset wins over a same-cycle frame_tick.
    always_ff @(posedge clk) begin
        fire_q <= btn_fire;
        if (clr) begin
            state_q <= ST_IDLE;
            inv_q   <= INIT_ARRAY;
            line_q  <= 5'd0;
            ship_q  <= SHIP_INIT;
            bx_q    <= 5'd0;
            by_q    <= 4'd0;
            fly_q   <= 1'b0;
            bdiv_q  <= 6'd0;
            sdiv_q  <= 6'd0;
            idiv_q  <= 6'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            line_q  <= line_d;
            ship_q  <= ship_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            fly_q   <= fly_d;
            bdiv_q  <= bdiv_d;
            sdiv_q  <= sdiv_d;
            idiv_q  <= idiv_d;
            pend_q  <= pend_d;
        end
    end

    assign invArray     = inv_q;
    assign invLine      = line_q;
    assign shipX        = ship_q;
    assign bulletX      = bx_q;
    assign bulletY      = by_q;
    assign bulletFlying = fly_q;
    assign status       = state_q;

endmodule
